// File: rtl/mdu_div_seq.sv
// mdu_div_seq: multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants
module mdu_div_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [XLEN-1:0] x_rs1,
    input  logic [XLEN-1:0] x_rs2,
    input  logic [2:0]      funct3,
    input  logic            inst_32,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] div_result
);
    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t          state_q;
    logic [XLEN-1:0] rs1_q, rs2_q, quo_q, rem_q, dvs_q, res_q;
    logic [2:0]      f3_q;
    logic            w_q, neg_q, rsgn_q, ready_q, valid_q;
    logic [CW-1:0]   cnt_q;

    logic            sgn, s1, s2, zero_div, ovf, special, ge;
    logic [XLEN-1:0] op1, op2, mag1, mag2, min_neg, spec_res, quo_init;
    logic [XLEN-1:0] quo_d, rem_d, fix_res, raw_d, res_d;
    logic [XLEN:0]   sh, diff;

    assign div_ready    = ready_q;
    assign result_valid = valid_q;
    assign div_result   = res_q;

    // operand preparation, one restoring step, sign fix-up and W sign extension
    always_comb begin
        sgn      = ~f3_q[0];
        op1      = w_q ? {{HW{sgn & rs1_q[HW-1]}}, rs1_q[HW-1:0]} : rs1_q;
        op2      = w_q ? {{HW{sgn & rs2_q[HW-1]}}, rs2_q[HW-1:0]} : rs2_q;
        s1       = sgn & op1[XLEN-1];
        s2       = sgn & op2[XLEN-1];
        mag1     = s1 ? -op1 : op1;
        mag2     = s2 ? -op2 : op2;
        min_neg  = w_q ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        zero_div = ~|op2;
        ovf      = sgn & (op1 == min_neg) & (&op2);
        special  = ~f3_q[2] | zero_div | ovf;
        spec_res = ~f3_q[2] ? '0 : zero_div ? (f3_q[1] ? op1 : '1) : (f3_q[1] ? '0 : op1);
        quo_init = w_q ? mag1 << HW : mag1;
        sh       = {rem_q, quo_q[XLEN-1]};
        diff     = sh - {1'b0, dvs_q};
        ge       = ~diff[XLEN];
        rem_d    = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
        quo_d    = {quo_q[XLEN-2:0], ge};
        fix_res  = f3_q[1] ? (rsgn_q ? -rem_q : rem_q) : (neg_q ? -quo_q : quo_q);
        raw_d    = (state_q == PREP) ? spec_res : fix_res;
        res_d    = w_q ? {{HW{raw_d[HW-1]}}, raw_d[HW-1:0]} : raw_d;
    end

    // control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            w_q     <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (div_valid) begin
                    rs1_q   <= x_rs1;
                    rs2_q   <= x_rs2;
                    f3_q    <= funct3;
                    w_q     <= inst_32;
                    ready_q <= 1'b0;
                    state_q <= PREP;
                end
                PREP: if (special) begin
                    res_q   <= res_d;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end else begin
                    quo_q   <= quo_init;
                    rem_q   <= '0;
                    dvs_q   <= mag2;
                    neg_q   <= s1 ^ s2;
                    rsgn_q  <= s1;
                    cnt_q   <= w_q ? CW'(HW) : CW'(XLEN);
                    state_q <= CALC;
                end
                CALC: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    res_q   <= res_d;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: if (result_ready) begin
                    res_q   <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_div_seq.sv
// tb_mdu_div_seq: directed vectors against an arithmetic reference model of the sequential divider
module tb_mdu_div_seq;
    logic        clk = 0, rst_n = 0, div_valid = 0, flush = 0, result_ready = 0, inst_32 = 0;
    logic [2:0]  funct3 = 0;
    logic [63:0] x_rs1 = 0, x_rs2 = 0;
    logic        div_ready, result_valid;
    logic [63:0] div_result;

    int errors = 0, checks = 0, cyc = 0;
    logic        m_busy, exp_valid, lit_en = 0, prev_rv = 0;
    int          m_age, m_lat, m_acc;
    logic [63:0] m_res, lit_res = 0;
    int          lit_lat = 0;

    always #5 clk = ~clk;

    mdu_div_seq #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .div_valid(div_valid), .div_ready(div_ready),
        .x_rs1(x_rs1), .x_rs2(x_rs2), .funct3(funct3), .inst_32(inst_32), .flush(flush),
        .result_valid(result_valid), .result_ready(result_ready), .div_result(div_result)
    );

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic is_spec(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f, input logic w);
        logic sg;
        sg = !f[0];
        if (!f[2]) return 1'b1;
        if (w) return b[31:0] == 0 || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return b == 0 || (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] ref_res(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f, input logic w);
        logic        sg;
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q, r;
        sg = !f[0];
        if (!f[2]) return 64'd0;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
            else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (sg) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            return sx32(f[1] ? r32 : q32);
        end
        if (b == 0) begin q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; end
        else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin q = a; r = 0; end
        else if (sg) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        else begin q = a / b; r = a % b; end
        return f[1] ? r : q;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // reference: busy from accept until the result is taken or killed
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
        end else if (flush) m_busy <= 1'b0;
        else if (!m_busy) begin
            if (div_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_lat  <= is_spec(x_rs1, x_rs2, funct3, inst_32) ? 1 : (inst_32 ? 34 : 66);
                m_res  <= ref_res(x_rs1, x_rs2, funct3, inst_32);
                m_acc  <= cyc + 1;
            end
        end else if (m_age >= m_lat && result_ready) m_busy <= 1'b0;
        else m_age <= m_age + 1;
    end

    assign exp_valid = m_busy && (m_age >= m_lat);

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // compare every cycle, and right after an asynchronous reset assertion
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) #1;
            chk("div_ready", div_ready, !m_busy);
            chk("result_valid", result_valid, exp_valid);
            chk("div_result", div_result, exp_valid ? m_res : 64'd0);
            if (lit_en && result_valid && !prev_rv) begin
                chk("lit_result", div_result, lit_res);
                chk("lit_latency", cyc - m_acc, lit_lat);
            end
            prev_rv = result_valid;
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f, input logic w);
        @(posedge clk); #1;
        x_rs1 = a; x_rs2 = b; funct3 = f; inst_32 = w; div_valid = 1;
        @(posedge clk); #1;
        div_valid = 0;
        x_rs1 = {$urandom, $urandom}; x_rs2 = {$urandom, $urandom};
        funct3 = 3'($urandom); inst_32 = 1'($urandom);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f, input logic w,
                          input logic [63:0] lr, input int ll, input int hold, input logic kill);
        lit_res = lr; lit_lat = ll; lit_en = 1;
        issue(a, b, f, w);
        for (int i = 0; i < 200 && !exp_valid; i++) begin
            div_valid = (i >= 5 && i < 8);
            @(posedge clk); #1;
        end
        div_valid = 0;
        repeat (hold) begin @(posedge clk); #1; end
        if (kill) flush = 1; else result_ready = 1;
        @(posedge clk); #1;
        flush = 0; result_ready = 0; lit_en = 0;
    endtask

    initial begin
        #23 rst_n = 1;
        run_op(-64'sd20, 64'd6, 3'b100, 0, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, 0);
        run_op(-64'sd20, 64'd6, 3'b110, 0, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 0);
        run_op(64'h1_FFFF_FFFE, 64'h7_0000_0001, 3'b101, 1, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0, 0);
        run_op(64'd7, 64'h1_0000_0000, 3'b111, 1, 64'd7, 1, 0, 0);
        run_op(64'd5, 64'd0, 3'b101, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 0, 64'h8000_0000_0000_0000, 1, 0, 0);
        run_op(64'h8000_0000, 64'hFFFF_FFFF, 3'b110, 1, 64'd0, 1, 0, 0);
        run_op(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);
        run_op(64'hFFFF_FFEC, 64'd6, 3'b100, 1, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b101, 0, 64'h0FFF_FFFF_FFFF_FFFF, 66, 0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b111, 0, 64'hF, 66, 0, 0);
        run_op(64'd1234, 64'd5, 3'b000, 0, 64'd0, 1, 0, 0);
        // backpressure: result held 10 cycles in DONE
        run_op(64'hFFFF_FFF9, 64'd2, 3'b110, 1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 10, 0);
        // flush wins in DONE
        run_op(64'd9, 64'd0, 3'b101, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3, 1);
        // flush in CALC, then a fresh request
        issue(64'd1000, 64'd3, 3'b100, 0);
        repeat (20) begin @(posedge clk); #1; end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        run_op(64'd100, 64'd7, 3'b101, 0, 64'd14, 66, 0, 0);
        // flush beats a simultaneous request in IDLE
        @(posedge clk); #1;
        x_rs1 = 64'd50; x_rs2 = 64'd5; funct3 = 3'b101; inst_32 = 0; div_valid = 1; flush = 1;
        @(posedge clk); #1;
        div_valid = 0; flush = 0;
        repeat (3) begin @(posedge clk); #1; end
        // asynchronous reset mid-CALC
        issue(-64'sd20, 64'd6, 3'b100, 0);
        repeat (30) @(posedge clk);
        #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        run_op(64'd100, 64'd7, 3'b111, 0, 64'd2, 66, 0, 0);
        repeat (3) @(posedge clk);
        #1 $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
